prbs4_checker: RTL and testbench

- Serial receiver/checker for the 4-bit Fibonacci LFSR bit stream produced by the team's PRBS generator.
- Generator recurrence: state shifts right, feedback into the MSB = r[1]^r[0], transmitted bit = r[0]. The stream therefore obeys b[n+4] = b[n+1] ^ b[n], period 15.
- The checker self-synchronises to the incoming stream, declares lock, then flywheels its own reference and counts bit errors.
- Sits at the receive end of link/BIST loopback paths.

---
 rtl/prbs4_checker.sv | 144 ++++++++++++++
 tb/tb_prbs4_checker.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/prbs4_checker.sv
// Self-synchronising checker for the 4-bit Fibonacci PRBS stream (b[n+4] = b[n+1] ^ b[n]).
// It searches, verifies a run of correct predictions, then flywheels its own reference and counts bit errors.
module prbs4_checker #(
  parameter int LOCK_CNT   = 8,
  parameter int UNLOCK_CNT = 3,
  parameter int ERR_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             din,
  input  logic             din_valid,
  input  logic             clr_err,
  output logic             locked,
  output logic             err_pulse,
  output logic             sync_loss,
  output logic [ERR_W-1:0] err_cnt
);

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } state_t;

  localparam logic [7:0]       LOCK_LAST = 8'(LOCK_CNT - 1);
  localparam logic [3:0]       MISS_LAST = 4'(UNLOCK_CNT - 1);
  localparam logic [ERR_W-1:0] ERR_ONE   = ERR_W'(1);
  localparam logic [ERR_W-1:0] ERR_MAX   = '1;

  state_t           state_q, state_d;
  logic [3:0]       h_q, h_d;
  logic [2:0]       fill_q, fill_d;
  logic [7:0]       match_cnt_q, match_cnt_d;
  logic [3:0]       miss_cnt_q, miss_cnt_d;
  logic             locked_q, locked_d;
  logic             err_pulse_q, err_pulse_d;
  logic             sync_loss_q, sync_loss_d;
  logic [ERR_W-1:0] err_cnt_q, err_cnt_d;

  logic pred;
  assign pred = h_q[1] ^ h_q[0];

  always_comb begin
    state_d     = state_q;
    h_d         = h_q;
    fill_d      = fill_q;
    match_cnt_d = match_cnt_q;
    miss_cnt_d  = miss_cnt_q;
    locked_d    = locked_q;
    err_pulse_d = 1'b0;
    sync_loss_d = 1'b0;
    err_cnt_d   = err_cnt_q;

    if (din_valid) begin
      case (state_q)
        SEARCH: begin
          h_d    = {din, h_q[3:1]};
          fill_d = fill_q + 3'd1;
          if (fill_q == 3'd3) begin
            state_d     = VERIFY;
            match_cnt_d = 8'd0;
          end
        end

        VERIFY: begin
          h_d = {din, h_q[3:1]};
          // All-zero history is the LFSR lockup state and must never build lock.
          if ((din == pred) && (h_q != 4'b0000)) begin
            match_cnt_d = match_cnt_q + 8'd1;
            if (match_cnt_q == LOCK_LAST) begin
              state_d    = LOCKED;
              locked_d   = 1'b1;
              miss_cnt_d = 4'd0;
            end
          end else begin
            match_cnt_d = 8'd0;
          end
        end

        LOCKED: begin
          // Flywheel: the reference regenerates itself so a bad bit cannot corrupt it.
          h_d = {pred, h_q[3:1]};
          if (din == pred) begin
            miss_cnt_d = 4'd0;
          end else begin
            err_pulse_d = 1'b1;
            if (err_cnt_q != ERR_MAX) begin
              err_cnt_d = err_cnt_q + ERR_ONE;
            end
            if (miss_cnt_q == MISS_LAST) begin
              state_d     = SEARCH;
              locked_d    = 1'b0;
              sync_loss_d = 1'b1;
              h_d         = 4'b0000;
              fill_d      = 3'd0;
              miss_cnt_d  = 4'd0;
            end else begin
              miss_cnt_d = miss_cnt_q + 4'd1;
            end
          end
        end

        default: begin
          state_d = SEARCH;
        end
      endcase
    end

    // Clear wins over a coincident increment; the error pulse is unaffected.
    if (clr_err) begin
      err_cnt_d = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= SEARCH;
      h_q         <= 4'b0000;
      fill_q      <= 3'd0;
      match_cnt_q <= 8'd0;
      miss_cnt_q  <= 4'd0;
      locked_q    <= 1'b0;
      err_pulse_q <= 1'b0;
      sync_loss_q <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      h_q         <= h_d;
      fill_q      <= fill_d;
      match_cnt_q <= match_cnt_d;
      miss_cnt_q  <= miss_cnt_d;
      locked_q    <= locked_d;
      err_pulse_q <= err_pulse_d;
      sync_loss_q <= sync_loss_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign locked    = locked_q;
  assign err_pulse = err_pulse_q;
  assign sync_loss = sync_loss_q;
  assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_prbs4_checker.sv
// Directed bench for prbs4_checker: a reference LFSR drives the stream, and each task checks one scenario.
// A second instance with a 4-bit counter covers saturation.
module tb_prbs4_checker;

  logic        clk;
  logic        reset;
  logic        din;
  logic        din_valid;
  logic        clr_err;
  logic        locked;
  logic        err_pulse;
  logic        sync_loss;
  logic [15:0] err_cnt;
  logic        locked4;
  logic        err_pulse4;
  logic        sync_loss4;
  logic [3:0]  err_cnt4;

  int checks = 0;
  int errors = 0;

  logic [3:0] g;

  prbs4_checker dut (
    .clk(clk), .reset(reset), .din(din), .din_valid(din_valid), .clr_err(clr_err),
    .locked(locked), .err_pulse(err_pulse), .sync_loss(sync_loss), .err_cnt(err_cnt)
  );

  prbs4_checker #(.ERR_W(4)) dut4 (
    .clk(clk), .reset(reset), .din(din), .din_valid(din_valid), .clr_err(clr_err),
    .locked(locked4), .err_pulse(err_pulse4), .sync_loss(sync_loss4), .err_cnt(err_cnt4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic send(input logic b, input logic v, input logic c);
    din       = b;
    din_valid = v;
    clr_err   = c;
    @(posedge clk);
    #1;
    din_valid = 1'b0;
    clr_err   = 1'b0;
  endtask

  task automatic send_gen(input logic inv, input logic c);
    send(g[0] ^ inv, 1'b1, c);
    g = {g[1] ^ g[0], g[3:1]};
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    g = 4'b0001;
  endtask

  task automatic test_reset();
    #2 reset = 1'b1;
    #2;
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL reset_locked got %b want 0", locked); end
    checks++; if (err_pulse !== 1'b0) begin errors++; $display("FAIL reset_err_pulse got %b want 0", err_pulse); end
    checks++; if (sync_loss !== 1'b0) begin errors++; $display("FAIL reset_sync_loss got %b want 0", sync_loss); end
    checks++; if (err_cnt !== 16'd0) begin errors++; $display("FAIL reset_err_cnt got %0d want 0", err_cnt); end
    $display("test_reset: outputs after reset locked=%b err_cnt=%0d", locked, err_cnt);
    @(posedge clk);
    #1 reset = 1'b0;
    g = 4'b0001;
  endtask

  task automatic test_lock();
    int pulses = 0;
    for (int i = 1; i <= 11; i++) send_gen(1'b0, 1'b0);
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL lock_early got %b want 0 after 11 bits", locked); end
    send_gen(1'b0, 1'b0);
    checks++; if (locked !== 1'b1) begin errors++; $display("FAIL lock_at_12 got %b want 1 after 12 bits", locked); end
    for (int i = 13; i <= 150; i++) begin
      send_gen(1'b0, 1'b0);
      if (err_pulse) pulses++;
    end
    checks++; if (pulses != 0) begin errors++; $display("FAIL clean_pulses got %0d want 0", pulses); end
    checks++; if (err_cnt !== 16'd0) begin errors++; $display("FAIL clean_err_cnt got %0d want 0", err_cnt); end
    $display("test_lock: locked=%b err_cnt=%0d pulses=%0d over 150 bits", locked, err_cnt, pulses);
  endtask

  task automatic test_single_error();
    int pulses = 0;
    send_gen(1'b1, 1'b0);
    checks++; if (err_pulse !== 1'b1) begin errors++; $display("FAIL single_pulse got %b want 1", err_pulse); end
    checks++; if (err_cnt !== 16'd1) begin errors++; $display("FAIL single_cnt got %0d want 1", err_cnt); end
    checks++; if (locked !== 1'b1) begin errors++; $display("FAIL single_locked got %b want 1", locked); end
    send_gen(1'b0, 1'b0);
    checks++; if (err_pulse !== 1'b0) begin errors++; $display("FAIL single_pulse_width got %b want 0", err_pulse); end
    for (int i = 0; i < 30; i++) begin
      send_gen(1'b0, 1'b0);
      if (err_pulse) pulses++;
    end
    checks++; if (pulses != 0 || err_cnt !== 16'd1) begin
      errors++; $display("FAIL single_flywheel got pulses=%0d cnt=%0d want 0/1", pulses, err_cnt);
    end
    $display("test_single_error: err_cnt=%0d locked=%b later_pulses=%0d", err_cnt, locked, pulses);
  endtask

  task automatic test_burst();
    send(1'b0, 1'b0, 1'b1);
    send_gen(1'b1, 1'b0);
    send_gen(1'b1, 1'b0);
    checks++; if (sync_loss !== 1'b0 || locked !== 1'b1) begin
      errors++; $display("FAIL burst_two got sync_loss=%b locked=%b want 0/1", sync_loss, locked);
    end
    send_gen(1'b1, 1'b0);
    checks++; if (sync_loss !== 1'b1) begin errors++; $display("FAIL burst_sync_loss got %b want 1", sync_loss); end
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL burst_unlock got %b want 0", locked); end
    checks++; if (err_cnt !== 16'd3) begin errors++; $display("FAIL burst_cnt got %0d want 3", err_cnt); end
    for (int i = 1; i <= 11; i++) begin
      send_gen(1'b0, 1'b0);
      if (i == 1) begin
        checks++; if (sync_loss !== 1'b0) begin errors++; $display("FAIL burst_sync_width got %b want 0", sync_loss); end
      end
    end
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL relock_early got %b want 0", locked); end
    send_gen(1'b0, 1'b0);
    checks++; if (locked !== 1'b1) begin errors++; $display("FAIL relock got %b want 1", locked); end
    $display("test_burst: err_cnt=%0d relocked=%b", err_cnt, locked);
  endtask

  task automatic test_constant();
    int seen_lock = 0;
    do_reset();
    for (int i = 0; i < 100; i++) begin
      send(1'b0, 1'b1, 1'b0);
      if (locked) seen_lock++;
    end
    checks++; if (seen_lock != 0 || err_cnt !== 16'd0) begin
      errors++; $display("FAIL const0 got lock_cycles=%0d cnt=%0d want 0/0", seen_lock, err_cnt);
    end
    for (int i = 0; i < 100; i++) begin
      send(1'b1, 1'b1, 1'b0);
      if (locked) seen_lock++;
    end
    checks++; if (seen_lock != 0 || err_cnt !== 16'd0) begin
      errors++; $display("FAIL const1 got lock_cycles=%0d cnt=%0d want 0/0", seen_lock, err_cnt);
    end
    $display("test_constant: lock_cycles=%0d err_cnt=%0d", seen_lock, err_cnt);
  endtask

  task automatic test_sparse_valid();
    do_reset();
    for (int c = 1; c <= 36; c++) begin
      if (c % 3 == 0) send_gen(1'b0, 1'b0);
      else send(1'b1, 1'b0, 1'b0);
      if (c == 35) begin
        checks++; if (locked !== 1'b0) begin errors++; $display("FAIL sparse_early got %b want 0", locked); end
      end
    end
    checks++; if (locked !== 1'b1) begin errors++; $display("FAIL sparse_lock got %b want 1 at cycle 36", locked); end
    $display("test_sparse_valid: locked=%b at cycle 36", locked);
  endtask

  task automatic test_saturation();
    send(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 100; i++) send_gen(i % 5 == 4, 1'b0);
    checks++; if (err_cnt4 !== 4'd15) begin errors++; $display("FAIL sat_cnt4 got %0d want 15", err_cnt4); end
    checks++; if (locked4 !== 1'b1) begin errors++; $display("FAIL sat_locked4 got %b want 1", locked4); end
    checks++; if (err_cnt !== 16'd20) begin errors++; $display("FAIL sat_cnt16 got %0d want 20", err_cnt); end
    $display("test_saturation: err_cnt4=%0d err_cnt=%0d locked4=%b", err_cnt4, err_cnt, locked4);
  endtask

  task automatic test_clr_coincident();
    send_gen(1'b1, 1'b1);
    checks++; if (err_pulse !== 1'b1) begin errors++; $display("FAIL clr_pulse got %b want 1", err_pulse); end
    checks++; if (err_cnt !== 16'd0) begin errors++; $display("FAIL clr_cnt got %0d want 0", err_cnt); end
    send_gen(1'b0, 1'b0);
    $display("test_clr_coincident: err_pulse seen, err_cnt=%0d", err_cnt);
  endtask

  task automatic test_reset_async();
    send_gen(1'b1, 1'b0);
    // Asserted between edges; the outputs must clear before the next rising edge.
    #2 reset = 1'b1;
    #1;
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL async_locked got %b want 0", locked); end
    checks++; if (err_cnt !== 16'd0) begin errors++; $display("FAIL async_cnt got %0d want 0", err_cnt); end
    checks++; if (err_pulse !== 1'b0) begin errors++; $display("FAIL async_pulse got %b want 0", err_pulse); end
    checks++; if (sync_loss !== 1'b0) begin errors++; $display("FAIL async_sync_loss got %b want 0", sync_loss); end
    $display("test_reset_async: locked=%b err_cnt=%0d", locked, err_cnt);
    @(posedge clk);
    #1 reset = 1'b0;
  endtask

  initial begin
    reset     = 1'b0;
    din       = 1'b0;
    din_valid = 1'b0;
    clr_err   = 1'b0;
    g         = 4'b0001;
    test_reset();
    test_lock();
    test_single_error();
    test_burst();
    test_constant();
    test_sparse_valid();
    test_saturation();
    test_clr_coincident();
    test_reset_async();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
